controlador_rolhas: RTL and testbench
=====================================

// Module: controlador_rolhas
// PURPOSE
//  Sequences the corking station: holds the 7-bit cork stock (0..99), issues one seal
//  command per bottle, requests supply refills when stock runs low, raises a fault on
//  seal timeout. Drives tens/units BCD of stock to the 7-segment display path.
// PARAMETERS
//  MAX_STOCK     99  saturation ceiling of stock (must be <= 99)
//  REFILL_QTY    20  corks added per refill_ack
//  LOW_THRESH     5  stock < LOW_THRESH forces REFILL from IDLE
//  SEAL_TIMEOUT  15  cycles allowed in SEAL before FAULT (4-bit timer)
// PORTS
//  clk           in   1  station clock, rising edge
//  rst_n         in   1  asynchronous reset, active-low
//  enable        in   1  station running; low holds FSM in IDLE
//  bottle_in     in   1  1-cycle pulse: bottle at corking position
//  seal_done     in   1  1-cycle pulse: actuator finished seal
//  refill_ack    in   1  1-cycle pulse: supply delivered REFILL_QTY corks
//  clear_fault   in   1  1-cycle pulse: leave FAULT
//  seal_cmd      out  1  high for whole SEAL state
//  refill_req    out  1  high for whole REFILL state
//  alarm         out  1  high in FAULT
//  overrun       out  1  sticky: bottle lost (pending already full)
//  stock         out  7  current cork count, binary
//  tens, units   out  4  registered BCD of stock
// BEHAVIOUR
//  Reset: state=IDLE, stock=0, pend=0, timer=0, all outputs 0, tens=units=0.
//  States IDLE=0, SEAL=1, REFILL=2, FAULT=3 (2-bit, registered).
//  IDLE (enable=1), priority order: stock<LOW_THRESH -> REFILL;
//   else (bottle_in|pend) -> SEAL, pend cleared; else stay. enable=0 -> stay IDLE.
//  SEAL: timer increments each cycle; seal_done -> stock-1, IDLE, timer=0;
//   timer==SEAL_TIMEOUT without seal_done -> FAULT, stock unchanged.
//  REFILL: refill_ack -> stock=min(stock+REFILL_QTY, MAX_STOCK) (8-bit add), IDLE.
//  FAULT: alarm=1; only clear_fault -> IDLE; bottle_in ignored (no pend, no overrun).
//  bottle_in outside IDLE (SEAL/REFILL): sets pend; if pend already 1 -> overrun=1
//   (sticky until rst_n). bottle_in in IDLE when going to REFILL sets pend.
//  Simultaneous seal_done+bottle_in in SEAL: decrement and set pend same edge.
//  stock never decrements below 0: SEAL entered only with stock>=LOW_THRESH>=1.
//  tens/units: registered from stock, 1-cycle latency after stock changes.
//  seal_done/refill_ack outside their state ignored.
//  rst_n low mid-SEAL/REFILL: immediate return to reset values, pend lost.
// CONFIGURATION
//  SEALED_COUNT_EN defined: adds outputs sealed_tens[3:0], sealed_units[3:0];
//   7-bit count of completed seals, +1 per seal_done in SEAL, wraps 99->0, reset 0,
//   BCD registered with 1-cycle latency (second converter instance).
//  Undefined: ports and counter absent; all other behaviour identical.
// STRUCTURE
//  Shared package rolhas_pkg: state encodings, MAX_BCD=99, BCD digit width 4.
//  Sub-module: conversor_bcd_rolhas (combinational 7-bit -> tens/units),
//   instanced once (twice with SEALED_COUNT_EN); registers live in the top.
// TESTING
//  1 Reset release, enable=1 -> REFILL next cycle, refill_req=1; refill_ack ->
//    stock=20, next cycle tens=2 units=0.
//  2 stock=20, bottle_in, seal_done 3 cycles later -> seal_cmd high 3 cycles,
//    stock=19, tens=1 units=9.
//  3 stock=90, force REFILL via LOW_THRESH=95 override, refill_ack -> stock=99 (sat).
//  4 SEAL with no seal_done -> FAULT after 15 cycles, alarm=1; clear_fault -> IDLE.
//  5 Two bottle_in during SEAL -> pend served next SEAL; third -> overrun=1.
//  6 stock=5, seal completes -> stock=4 -> REFILL before pending bottle sealed.

Source files
------------

// File: rtl/rolhas_pkg.sv
// Shared definitions for the corking station controller.
//   estado_t  : FSM state encoding (IDLE=0, SEAL=1, REFILL=2, FAULT=3)
//   MAX_BCD   : largest value the two-digit BCD display path can show
//   BCD_W     : width of one BCD digit
//   COUNT_W   : width of the binary cork / seal counters
//   sat_add   : saturating add used when a refill lands on the stock
package rolhas_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEAL   = 2'd1,
    ST_REFILL = 2'd2,
    ST_FAULT  = 2'd3
  } estado_t;

  localparam int          BCD_W   = 4;
  localparam int          COUNT_W = 7;
  localparam logic [6:0]  MAX_BCD = 7'd99;

  // Adds qty to base in 8 bits so the carry past 127 is never lost,
  // then clamps the result to ceil.
  function automatic logic [6:0] sat_add(input logic [6:0] base,
                                         input logic [7:0] qty,
                                         input logic [6:0] ceil);
    logic [7:0] sum;
    sum = {1'b0, base} + qty;
    if (sum > {1'b0, ceil}) begin
      sat_add = ceil;
    end else begin
      sat_add = sum[6:0];
    end
  endfunction

endpackage

// File: rtl/conversor_bcd_rolhas.sv
// Combinational binary to two-digit BCD converter for the stock display.
//   value : 7-bit binary input (values above 99 are shown as 99)
//   tens  : BCD tens digit
//   units : BCD units digit
module conversor_bcd_rolhas
  import rolhas_pkg::*;
(
  input  logic [COUNT_W-1:0] value,
  output logic [BCD_W-1:0]   tens,
  output logic [BCD_W-1:0]   units
);

  logic [COUNT_W-1:0] clip_s;
  logic [BCD_W-1:0]   tens_s;

  // Compare ladder instead of a divider: the largest multiple of ten not
  // above the input selects the tens digit, the remainder is the units digit.
  always_comb begin
    clip_s = (value > MAX_BCD) ? MAX_BCD : value;
    tens_s = 4'd0;
    for (int i = 1; i <= 9; i++) begin
      tens_s = (clip_s >= 7'(i * 10)) ? 4'(i) : tens_s;
    end
    tens  = tens_s;
    units = 4'(clip_s - (7'(tens_s) * 7'd10));
  end

endmodule

// File: rtl/controlador_rolhas.sv
// Corking station sequencer: keeps the cork stock, issues one seal command
// per bottle, requests refills when stock runs low and raises an alarm when
// a seal does not finish in time. Stock is also presented as registered BCD.
//
// Ports:
//   clk, rst_n      : station clock (rising edge), asynchronous active-low reset
//   enable          : station running; low keeps the FSM in IDLE
//   bottle_in       : 1-cycle pulse, bottle at corking position
//   seal_done       : 1-cycle pulse, actuator finished the seal
//   refill_ack      : 1-cycle pulse, supply delivered REFILL_QTY corks
//   clear_fault     : 1-cycle pulse, leave FAULT
//   seal_cmd        : high for the whole SEAL state
//   refill_req      : high for the whole REFILL state
//   alarm           : high in FAULT
//   overrun         : sticky, a bottle arrived while one was already pending
//   stock           : cork count, binary
//   tens, units     : registered BCD of stock (one cycle behind stock)
//
// Optional build macro SEALED_COUNT_EN adds sealed_tens/sealed_units, the
// registered BCD of a wrapping 0..99 count of completed seals.
module controlador_rolhas
  import rolhas_pkg::*;
#(
  parameter int MAX_STOCK    = 99,
  parameter int REFILL_QTY   = 20,
  parameter int LOW_THRESH   = 5,
  parameter int SEAL_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               bottle_in,
  input  logic               seal_done,
  input  logic               refill_ack,
  input  logic               clear_fault,
  output logic               seal_cmd,
  output logic               refill_req,
  output logic               alarm,
  output logic               overrun,
  output logic [COUNT_W-1:0] stock,
  output logic [BCD_W-1:0]   tens,
  output logic [BCD_W-1:0]   units
`ifdef SEALED_COUNT_EN
  ,
  output logic [BCD_W-1:0]   sealed_tens,
  output logic [BCD_W-1:0]   sealed_units
`endif
);

  localparam logic [6:0] MAX_STOCK_C = 7'(MAX_STOCK);
  localparam logic [7:0] REFILL_C    = 8'(REFILL_QTY);
  localparam logic [6:0] LOW_C       = 7'(LOW_THRESH);
  localparam logic [3:0] TIMEOUT_C   = 4'(SEAL_TIMEOUT);

  estado_t            state_r, state_nx_s;
  logic [COUNT_W-1:0] stock_r, stock_nx_s;
  logic               pend_r, pend_nx_s;
  logic [3:0]         timer_r, timer_nx_s;
  logic               overrun_r, overrun_nx_s;
  logic               seal_cmd_r, refill_req_r, alarm_r;
  logic [BCD_W-1:0]   tens_r, units_r;
  logic [BCD_W-1:0]   tens_s, units_s;

  // Next-state, stock, pending-bottle and seal-timer logic.
  always_comb begin
    state_nx_s   = state_r;
    stock_nx_s   = stock_r;
    pend_nx_s    = pend_r;
    timer_nx_s   = timer_r;
    overrun_nx_s = overrun_r;

    case (state_r)
      ST_IDLE: begin
        timer_nx_s = 4'd0;
        if (enable) begin
          if (stock_r < LOW_C) begin
            // Low stock wins over a waiting bottle; remember the bottle.
            state_nx_s = ST_REFILL;
            pend_nx_s  = pend_r | bottle_in;
          end else if (bottle_in || pend_r) begin
            state_nx_s = ST_SEAL;
            pend_nx_s  = 1'b0;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end

      ST_SEAL: begin
        if (seal_done) begin
          // SEAL is only entered with stock >= LOW_THRESH, the guard just
          // keeps a zero stock from wrapping.
          stock_nx_s = (stock_r != 7'd0) ? (stock_r - 7'd1) : stock_r;
          state_nx_s = ST_IDLE;
          timer_nx_s = 4'd0;
        end else if (timer_r == TIMEOUT_C) begin
          state_nx_s = ST_FAULT;
          timer_nx_s = 4'd0;
        end else begin
          timer_nx_s = timer_r + 4'd1;
        end
        if (bottle_in) begin
          if (pend_r) begin
            overrun_nx_s = 1'b1;
          end else begin
            pend_nx_s = 1'b1;
          end
        end else begin
          pend_nx_s = pend_r;
        end
      end

      ST_REFILL: begin
        if (refill_ack) begin
          stock_nx_s = sat_add(stock_r, REFILL_C, MAX_STOCK_C);
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_REFILL;
        end
        if (bottle_in) begin
          if (pend_r) begin
            overrun_nx_s = 1'b1;
          end else begin
            pend_nx_s = 1'b1;
          end
        end else begin
          pend_nx_s = pend_r;
        end
      end

      ST_FAULT: begin
        // Bottles arriving during a fault are not tracked.
        if (clear_fault) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_FAULT;
        end
      end

      default: begin
        state_nx_s = ST_IDLE;
        timer_nx_s = 4'd0;
      end
    endcase
  end

  // State, counters and state-decoded outputs; outputs follow the next state
  // so they are registered yet aligned with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      stock_r      <= 7'd0;
      pend_r       <= 1'b0;
      timer_r      <= 4'd0;
      overrun_r    <= 1'b0;
      seal_cmd_r   <= 1'b0;
      refill_req_r <= 1'b0;
      alarm_r      <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      stock_r      <= stock_nx_s;
      pend_r       <= pend_nx_s;
      timer_r      <= timer_nx_s;
      overrun_r    <= overrun_nx_s;
      seal_cmd_r   <= (state_nx_s == ST_SEAL);
      refill_req_r <= (state_nx_s == ST_REFILL);
      alarm_r      <= (state_nx_s == ST_FAULT);
    end
  end

  conversor_bcd_rolhas u_bcd_stock (
    .value (stock_r),
    .tens  (tens_s),
    .units (units_s)
  );

  // Display digits, registered from the stock register (one cycle behind).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens_r  <= 4'd0;
      units_r <= 4'd0;
    end else begin
      tens_r  <= tens_s;
      units_r <= units_s;
    end
  end

  assign seal_cmd   = seal_cmd_r;
  assign refill_req = refill_req_r;
  assign alarm      = alarm_r;
  assign overrun    = overrun_r;
  assign stock      = stock_r;
  assign tens       = tens_r;
  assign units      = units_r;

`ifdef SEALED_COUNT_EN
  logic [COUNT_W-1:0] sealed_cnt_r;
  logic [BCD_W-1:0]   sealed_tens_s, sealed_units_s;
  logic [BCD_W-1:0]   sealed_tens_r, sealed_units_r;

  // Completed-seal counter, wraps from 99 back to 0 to fit the display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sealed_cnt_r <= 7'd0;
    end else if ((state_r == ST_SEAL) && seal_done) begin
      sealed_cnt_r <= (sealed_cnt_r >= MAX_BCD) ? 7'd0 : (sealed_cnt_r + 7'd1);
    end else begin
      sealed_cnt_r <= sealed_cnt_r;
    end
  end

  conversor_bcd_rolhas u_bcd_sealed (
    .value (sealed_cnt_r),
    .tens  (sealed_tens_s),
    .units (sealed_units_s)
  );

  // Sealed-count display digits, one cycle behind the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sealed_tens_r  <= 4'd0;
      sealed_units_r <= 4'd0;
    end else begin
      sealed_tens_r  <= sealed_tens_s;
      sealed_units_r <= sealed_units_s;
    end
  end

  assign sealed_tens  = sealed_tens_r;
  assign sealed_units = sealed_units_r;
`endif

endmodule

// File: tb/tb_controlador_rolhas.sv
// Directed self-checking bench for controlador_rolhas. A second instance with
// a raised low-stock threshold exercises the refill saturation ceiling.
module tb_controlador_rolhas;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable, bottle_in, seal_done, refill_ack, clear_fault;
  logic       seal_cmd, refill_req, alarm, overrun;
  logic [6:0] stock;
  logic [3:0] tens, units;

  logic       enable2, refill_ack2, lt_zero;
  logic       lt_seal_cmd, lt_refill_req, lt_alarm, lt_overrun;
  logic [6:0] lt_stock;
  logic [3:0] lt_tens, lt_units;
`ifdef SEALED_COUNT_EN
  logic [3:0] sealed_tens, sealed_units, lt_sealed_tens, lt_sealed_units;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  controlador_rolhas dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .bottle_in   (bottle_in),
    .seal_done   (seal_done),
    .refill_ack  (refill_ack),
    .clear_fault (clear_fault),
    .seal_cmd    (seal_cmd),
    .refill_req  (refill_req),
    .alarm       (alarm),
    .overrun     (overrun),
    .stock       (stock),
    .tens        (tens),
    .units       (units)
`ifdef SEALED_COUNT_EN
    ,
    .sealed_tens (sealed_tens),
    .sealed_units(sealed_units)
`endif
  );

  controlador_rolhas #(.LOW_THRESH(95)) dut_lt (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable2),
    .bottle_in   (lt_zero),
    .seal_done   (lt_zero),
    .refill_ack  (refill_ack2),
    .clear_fault (lt_zero),
    .seal_cmd    (lt_seal_cmd),
    .refill_req  (lt_refill_req),
    .alarm       (lt_alarm),
    .overrun     (lt_overrun),
    .stock       (lt_stock),
    .tens        (lt_tens),
    .units       (lt_units)
`ifdef SEALED_COUNT_EN
    ,
    .sealed_tens (lt_sealed_tens),
    .sealed_units(lt_sealed_units)
`endif
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst_n = 1'b0; enable = 1'b0; bottle_in = 1'b0; seal_done = 1'b0;
    refill_ack = 1'b0; clear_fault = 1'b0;
    enable2 = 1'b0; refill_ack2 = 1'b0; lt_zero = 1'b0;
    repeat (3) tick();

    // Reset values
    chk("rst_stock",   32'(stock), 32'd0);
    chk("rst_tens",    32'(tens), 32'd0);
    chk("rst_units",   32'(units), 32'd0);
    chk("rst_seal",    32'(seal_cmd), 32'd0);
    chk("rst_refill",  32'(refill_req), 32'd0);
    chk("rst_alarm",   32'(alarm), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);

    rst_n = 1'b1;
    repeat (2) tick();
    chk("enable0_holds_idle", 32'(refill_req), 32'd0);

    // Saturation: threshold 95 keeps refilling 20,40,60,80 then clamps at 99
    enable2 = 1'b1;
    for (int r = 0; r < 5; r++) begin
      for (int n = 0; n < 10 && !lt_refill_req; n++) tick();
      chk("lt_refill_wait", 32'(lt_refill_req), 32'd1);
      refill_ack2 = 1'b1; tick(); refill_ack2 = 1'b0;
      if (r == 3) chk("lt_stock_80", 32'(lt_stock), 32'd80);
    end
    chk("lt_stock_sat", 32'(lt_stock), 32'd99);
    repeat (2) tick();
    chk("lt_no_more_refill", 32'(lt_refill_req), 32'd0);
    chk("lt_tens_99", 32'(lt_tens), 32'd9);
    chk("lt_units_99", 32'(lt_units), 32'd9);

    // Test 1: empty stock forces REFILL, ack adds 20
    enable = 1'b1; tick();
    chk("t1_refill_req", 32'(refill_req), 32'd1);
    chk("t1_no_seal", 32'(seal_cmd), 32'd0);
    refill_ack = 1'b1; tick(); refill_ack = 1'b0;
    chk("t1_stock_20", 32'(stock), 32'd20);
    chk("t1_refill_low", 32'(refill_req), 32'd0);
    tick();
    chk("t1_tens_2", 32'(tens), 32'd2);
    chk("t1_units_0", 32'(units), 32'd0);
    seal_done = 1'b1; tick(); seal_done = 1'b0;
    chk("seal_done_idle_ignored", 32'(stock), 32'd20);

    // Test 2: seal lasting three cycles
    bottle_in = 1'b1; tick(); bottle_in = 1'b0;
    chk("t2_seal_c1", 32'(seal_cmd), 32'd1);
    tick(); chk("t2_seal_c2", 32'(seal_cmd), 32'd1);
    tick(); chk("t2_seal_c3", 32'(seal_cmd), 32'd1);
    seal_done = 1'b1; tick(); seal_done = 1'b0;
    chk("t2_seal_off", 32'(seal_cmd), 32'd0);
    chk("t2_stock_19", 32'(stock), 32'd19);
    tick();
    chk("t2_tens_1", 32'(tens), 32'd1);
    chk("t2_units_9", 32'(units), 32'd9);

    // Test 4: seal timeout; timer visits 0..15 so SEAL lasts 16 cycles
    bottle_in = 1'b1; tick(); bottle_in = 1'b0;
    cnt = 0;
    for (int n = 0; n < 40 && !alarm; n++) begin
      if (seal_cmd) cnt++;
      tick();
    end
    chk("t4_seal_cycles", 32'(cnt), 32'd16);
    chk("t4_alarm", 32'(alarm), 32'd1);
    chk("t4_seal_off", 32'(seal_cmd), 32'd0);
    chk("t4_stock_kept", 32'(stock), 32'd19);
    bottle_in = 1'b1; tick(); bottle_in = 1'b0;
    tick();
    chk("t4_alarm_holds", 32'(alarm), 32'd1);
    clear_fault = 1'b1; tick(); clear_fault = 1'b0;
    chk("t4_alarm_clear", 32'(alarm), 32'd0);
    tick();
    chk("t4_fault_bottle_ignored", 32'(seal_cmd), 32'd0);
    chk("t4_no_overrun", 32'(overrun), 32'd0);

    // Test 5: pending bottle served, then double arrival overruns
    bottle_in = 1'b1; tick();
    chk("t5_seal_a", 32'(seal_cmd), 32'd1);
    tick(); bottle_in = 1'b0;
    chk("t5_pend_no_overrun", 32'(overrun), 32'd0);
    seal_done = 1'b1; tick(); seal_done = 1'b0;
    chk("t5_idle_gap", 32'(seal_cmd), 32'd0);
    chk("t5_stock_18", 32'(stock), 32'd18);
    tick();
    chk("t5_pend_served", 32'(seal_cmd), 32'd1);
    bottle_in = 1'b1; tick(); tick(); bottle_in = 1'b0;
    chk("t5_overrun", 32'(overrun), 32'd1);
    chk("t5_still_seal", 32'(seal_cmd), 32'd1);
    seal_done = 1'b1; tick(); seal_done = 1'b0;
    chk("t5_stock_17", 32'(stock), 32'd17);
    tick();
    chk("t5_pend_c_served", 32'(seal_cmd), 32'd1);
    seal_done = 1'b1; tick(); seal_done = 1'b0;
    chk("t5_stock_16", 32'(stock), 32'd16);
    tick();
    chk("t5_lost_bottle", 32'(seal_cmd), 32'd0);

    // Test 6: drain to 5, seal with simultaneous bottle, refill before it
    for (int k = 0; k < 11; k++) begin
      bottle_in = 1'b1; tick(); bottle_in = 1'b0;
      seal_done = 1'b1; tick(); seal_done = 1'b0;
    end
    chk("t6_stock_5", 32'(stock), 32'd5);
    bottle_in = 1'b1; tick();
    seal_done = 1'b1; tick(); bottle_in = 1'b0; seal_done = 1'b0;
    chk("t6_stock_4", 32'(stock), 32'd4);
    tick();
    chk("t6_refill_first", 32'(refill_req), 32'd1);
    chk("t6_no_seal_yet", 32'(seal_cmd), 32'd0);
    refill_ack = 1'b1; tick(); refill_ack = 1'b0;
    chk("t6_stock_24", 32'(stock), 32'd24);
    tick();
    chk("t6_pend_sealed", 32'(seal_cmd), 32'd1);
    seal_done = 1'b1; tick(); seal_done = 1'b0;
    chk("t6_stock_23", 32'(stock), 32'd23);
    chk("t6_overrun_sticky", 32'(overrun), 32'd1);

    // Asynchronous reset in the middle of SEAL
    bottle_in = 1'b1; tick(); bottle_in = 1'b0;
    chk("rst_mid_seal_pre", 32'(seal_cmd), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_seal_cmd", 32'(seal_cmd), 32'd0);
    chk("rst_mid_stock", 32'(stock), 32'd0);
    chk("rst_mid_overrun", 32'(overrun), 32'd0);
    tick(); rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
